// File: rtl/layer_stream_ctrl.sv
// ============================================================================
// Module      : layer_stream_ctrl
// Description : Frame sequencer for one fused conv/pool layer stage. It feeds
//               an input frame from a synchronous RAM into the layer and
//               stores the layer results in an output RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_stream_ctrl #(
    parameter int  WIDTH     = 112,
    parameter int  DIN_W     = 96,
    parameter int  DOUT_W    = 256,
    parameter int  DRAIN_MAX = 1024,
    localparam int c_DIM     = WIDTH * WIDTH,
    localparam int c_DOUT    = (WIDTH / 2) * (WIDTH / 2),
    localparam int c_RA_W    = (c_DIM > 1) ? $clog2(c_DIM) : 1,
    localparam int c_WA_W    = (c_DOUT > 1) ? $clog2(c_DOUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              rd_en,
    output logic [c_RA_W-1:0] rd_addr,
    input  logic [DIN_W-1:0]  rd_data,
    output logic              lyr_valid,
    output logic [DIN_W-1:0]  lyr_data,
    input  logic              lyr_vout,
    input  logic [DOUT_W-1:0] lyr_dout,
    output logic              wr_en,
    output logic [c_WA_W-1:0] wr_addr,
    output logic [DOUT_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_OC_W = $clog2(c_DOUT + 1);
    localparam int c_TM_W = $clog2(DRAIN_MAX + 1);

    localparam logic [c_RA_W-1:0] c_LAST_RD  = c_RA_W'(c_DIM - 1);
    localparam logic [c_OC_W-1:0] c_OUT_FULL = c_OC_W'(c_DOUT);
    localparam logic [c_TM_W-1:0] c_TMO_LAST = c_TM_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_lyr_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [c_RA_W-1:0] r_rd_addr;
    logic [c_OC_W-1:0] r_out_cnt;
    logic [c_TM_W-1:0] r_tmo_cnt;

    logic w_active;
    logic w_rd_issue;
    logic w_out_full;
    logic w_wr;

    assign w_active   = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_rd_issue = (r_state == S_FEED) && !hold;
    assign w_out_full = (r_out_cnt == c_OUT_FULL);
    assign w_wr       = w_active && lyr_vout && !w_out_full;

    // RAM data arrives together with the registered read strobe, so it is
    // passed straight through and masked whenever the strobe is low.
    assign rd_en     = w_rd_issue;
    assign rd_addr   = r_rd_addr;
    assign lyr_valid = r_lyr_valid;
    assign lyr_data  = r_lyr_valid ? rd_data : '0;
    assign wr_en     = w_wr;
    assign wr_addr   = r_out_cnt[c_WA_W-1:0];
    assign wr_data   = w_wr ? lyr_dout : '0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lyr_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_addr   <= '0;
            r_out_cnt   <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_lyr_valid <= w_rd_issue;
            r_done      <= 1'b0;

            if (w_wr) begin
                r_out_cnt <= r_out_cnt + c_OC_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FEED;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_FEED: begin
                    if (w_rd_issue) begin
                        if (r_rd_addr == c_LAST_RD) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + c_RA_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (lyr_vout) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TM_W'(1);
                    end
                    if (w_out_full) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (!lyr_vout && (r_tmo_cnt == c_TMO_LAST)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_rd_addr <= '0;
                    r_out_cnt <= '0;
                    r_tmo_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Any layer output that cannot be stored (frame already full, or
            // arriving outside a frame) is flagged; this outranks a start clear.
            if (lyr_vout && !w_wr) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
